// File: rtl/pushbutton_pkg.sv
// Shared edge-mode type, register map and sizing helpers for the pushbutton PIO.
package pushbutton_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_t;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_EDGE_MODE = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
   localparam logic [2:0] ADDR_SYNC      = 3'd4;

   // Counter width able to hold 0 .. cycles-1 (clog2), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = 32'd1;
      while ((32'd1 << w) < cycles) begin
         w = w + 32'd1;
      end
      return w;
   endfunction

   function automatic logic edge_hit(input edge_mode_t mode, input logic cur, input logic prv);
      logic hit;
      case (mode)
         EDGE_RISE: hit = cur & ~prv;
         EDGE_FALL: hit = ~cur & prv;
         EDGE_BOTH: hit = cur ^ prv;
         EDGE_OFF:  hit = 1'b0;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One button channel: synchronizer, debounce counter, accepted level and edge detect.
// The counter exists only when PUSHBUTTON_DEBOUNCE_EN is defined.
module pb_debounce_chan
   import pushbutton_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din,
   input  edge_mode_t mode,
   output logic       sync,
   output logic       stable,
   output logic       edge_det
);

   logic meta_r;
   logic sync_r;
   logic stable_r;
   logic prev_r;

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
      end
   end

`ifdef PUSHBUTTON_DEBOUNCE_EN
   localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

   logic [CW-1:0] cnt_r;

   // A new level is accepted only after it differs from the stable level for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the stable level restarts.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r    <= '0;
         stable_r <= 1'b0;
      end else if (sync_r == stable_r) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         stable_r <= sync_r;
         cnt_r    <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(32'd1);
      end
   end
`else
   // DEBOUNCE_CYCLES has no effect without the counter.
   logic unused_cfg_s;
   assign unused_cfg_s = ^DEBOUNCE_CYCLES;

   // Without debounce the accepted level simply follows the synchronizer.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_r <= 1'b0;
      end else begin
         stable_r <= sync_r;
      end
   end
`endif

   // One-cycle delayed copy of the accepted level for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= stable_r;
      end
   end

   assign sync     = sync_r;
   assign stable   = stable_r;
   assign edge_det = edge_hit(mode, stable_r, prev_r);

endmodule

// File: rtl/pushbutton_debounce_pio.sv
// Avalon-MM pushbutton PIO: per-channel debounce, edge capture and mask-gated level irq.
// Define PUSHBUTTON_DEBOUNCE_EN to build the per-channel debounce counters.
module pushbutton_debounce_pio
   import pushbutton_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0]   sync_s;
   logic [WIDTH-1:0]   stable_s;
   logic [WIDTH-1:0]   edge_s;
   logic [WIDTH-1:0]   cap_clr_s;
   logic               wr_en_s;
   logic [31:0]        rd_mux_s;
   logic [2*WIDTH-1:0] edge_mode_r;
   logic [WIDTH-1:0]   irq_mask_r;
   logic [WIDTH-1:0]   edge_cap_r;
   logic [31:0]        readdata_r;
   logic               unused_s;

   for (genvar n = 0; n < WIDTH; n++) begin : g_chan
      pb_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .din      (in_port[n]),
         .mode     (edge_mode_t'(edge_mode_r[2*n +: 2])),
         .sync     (sync_s[n]),
         .stable   (stable_s[n]),
         .edge_det (edge_s[n])
      );
   end

   // Write strobe and the write-one-to-clear mask for edge_capture.
   always_comb begin
      wr_en_s   = chipselect & ~write_n;
      cap_clr_s = '0;
      if (wr_en_s && (address == ADDR_EDGE_CAP)) begin
         cap_clr_s = writedata[WIDTH-1:0];
      end else begin
         cap_clr_s = '0;
      end
   end

   // Configuration registers: edge mode and interrupt mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_mode_r <= '0;
         irq_mask_r  <= '0;
      end else if (wr_en_s) begin
         case (address)
            ADDR_EDGE_MODE: edge_mode_r <= writedata[2*WIDTH-1:0];
            ADDR_IRQ_MASK:  irq_mask_r  <= writedata[WIDTH-1:0];
            default:        ;
         endcase
      end
   end

   // Sticky edge capture; a new edge overrides a simultaneous clear of its bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cap_r <= '0;
      end else begin
         edge_cap_r <= (edge_cap_r & ~cap_clr_s) | edge_s;
      end
   end

   // Read mux, zero-extended; unmapped addresses read zero.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (address)
         ADDR_DATA:      rd_mux_s[WIDTH-1:0]   = stable_s;
         ADDR_EDGE_MODE: rd_mux_s[2*WIDTH-1:0] = edge_mode_r;
         ADDR_IRQ_MASK:  rd_mux_s[WIDTH-1:0]   = irq_mask_r;
         ADDR_EDGE_CAP:  rd_mux_s[WIDTH-1:0]   = edge_cap_r;
         ADDR_SYNC:      rd_mux_s[WIDTH-1:0]   = sync_s;
         default:        rd_mux_s              = 32'h0000_0000;
      endcase
   end

   // Read data registered every cycle, independent of chipselect.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_r <= 32'h0000_0000;
      end else begin
         readdata_r <= rd_mux_s;
      end
   end

   assign readdata = readdata_r;
   assign irq      = |(edge_cap_r & irq_mask_r);
   assign unused_s = ^writedata;

endmodule

// File: doc/pushbutton_debounce_pio.md
PUSHBUTTON_DEBOUNCE_PIO -- requirements
Module: pushbutton_debounce_pio

Interface
REQ-001 Parameter WIDTH, default 4, number of input channels; legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, stable-cycle count required to accept a new level; legal range 2..2^20.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  raw asynchronous button levels.
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  level interrupt request.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-013 Per channel, a counter SHALL clear whenever sync equals the stable level, increment while they differ, and on reaching DEBOUNCE_CYCLES-1 while still differing SHALL load stable <= sync and clear.
REQ-014 Any sync toggle back to the stable level before acceptance SHALL discard the pending change (counter to 0).
REQ-015 Edge detection SHALL compare stable against its one-cycle-delayed copy (prev).
REQ-016 Per-channel 2-bit edge mode: 00 rising, 01 falling, 10 both, 11 disabled; channel n uses mode bits [2n+1:2n].
REQ-017 Register map, read: 0 stable levels; 1 edge mode; 2 irq_mask; 3 edge_capture; 4 sync (raw synchronized) levels; 5-7 read zero; unused upper bits read zero.
REQ-018 Writes (chipselect & ~write_n): 1 loads edge mode; 2 loads irq_mask[WIDTH-1:0]; 3 clears each edge_capture bit whose writedata bit is 1; writes to 0, 4-7 ignored.
REQ-019 readdata SHALL be registered every cycle from the current address mux regardless of chipselect: read latency exactly 1 cycle.
REQ-020 A detected edge SHALL set its edge_capture bit on the following clock edge.
REQ-021 Simultaneous clear-write and new edge on the same bit: set wins (bit stays 1).
REQ-022 irq SHALL equal |(edge_capture & irq_mask), combinational from registers, no extra latency.
REQ-023 Writing edge mode or mask SHALL not modify edge_capture.

Reset
REQ-024 On reset: sync, stable, prev, counters, edge_capture, irq_mask, readdata all 0; edge mode all 00 (rising); irq 0.
REQ-025 Reset asserted mid-debounce SHALL abandon the pending change; no edge SHALL be generated by reset deassertion alone.

Configuration
REQ-026 Macro PUSHBUTTON_DEBOUNCE_EN: defined -> debounce per REQ-013/014; undefined -> stable <= sync each cycle, counters not instantiated, DEBOUNCE_CYCLES ignored; all other behaviour identical.

Structure
REQ-027 Package pushbutton_pkg SHALL hold the edge-mode typedef (EDGE_RISE/FALL/BOTH/OFF), register address constants, and the counter-width function (clog2 of DEBOUNCE_CYCLES).
REQ-028 One sub-module pb_debounce_chan (synchronizer, counter, stable, prev, edge output for one channel) SHALL be instantiated WIDTH times via generate.

Verification
REQ-029 Macro defined, DEBOUNCE_CYCLES=4: in_port[0] 0->1 held -> stable[0]=1 exactly 2+4 cycles after the change reaches the synchronizer input; edge_capture[0]=1 one cycle later.
REQ-030 Glitch: in_port[1] high for 3 cycles then low, DEBOUNCE_CYCLES=4 -> stable, edge_capture, irq stay 0.
REQ-031 Mode 01 on ch2, mask=0x4, press then release -> capture set only on release; irq=1; write 0x4 to addr 3 -> irq=0 next cycle.
REQ-032 Clear-write to addr 3 in same cycle as new edge on that bit -> edge_capture bit remains 1.
REQ-033 Read addr 1 after writing 0x0000_00E4 -> readdata=0x0000_00E4 one cycle after address presented; addr 6 reads 0.
REQ-034 Reset pulse during pending debounce (counter=2) -> all registers 0, no edge captured after release of reset with input held.
